// File: rtl/wb_uart_if.sv
// if_wb: single-cycle Wishbone subset used by the J1 bridge.
// There is no ack; every strobed access completes in one clock.
interface if_wb;
  logic [15:0] adr;
  logic [15:0] dat_m;
  logic [15:0] dat_s;
  logic        stb;
  logic        cyc;
  logic        we;

  modport master (
    output adr, dat_m, stb, cyc, we,
    input  dat_s
  );

  modport slave (
    input  adr, dat_m, stb, cyc, we,
    output dat_s
  );
endinterface

// File: rtl/wb_uart.sv
// wb_uart: zero-wait-state Wishbone UART, 8N1 TX behind a small FIFO,
// 8N1 RX into a single holding register, status and baud divisor.
module wb_uart #(
  parameter logic [15:0] BASE      = 16'hF000,
  parameter int          TX_DEPTH  = 4,
  parameter logic [15:0] DIV_RESET = 16'd433
) (
  input  logic clk,
  input  logic rst_n,
  if_wb.slave  wb,
  input  logic rxd,
  output logic txd,
  output logic irq
);
  localparam int AW = $clog2(TX_DEPTH);

  typedef enum logic [1:0] {
    IDLE,
    START,
    DATA,
    STOP
  } st_t;

  logic       sel;
  logic       wr;
  logic       rd;
  logic [1:0] idx;
  logic       data_rd;
  logic       stat_wr;
  logic       unused_adr0;

  assign sel     = wb.stb & wb.cyc
                 & (wb.adr[15:3] == BASE[15:3]);
  assign idx     = wb.adr[2:1];
  assign wr      = sel & wb.we;
  assign rd      = sel & ~wb.we;
  assign data_rd = rd & (idx == 2'd0);
  assign stat_wr = wr & (idx == 2'd1);
  assign unused_adr0 = wb.adr[0];

  logic [15:0] div;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        rx_ovr;
  logic        rx_ferr;

  logic [7:0]  mem [TX_DEPTH];
  logic [AW:0] wp;
  logic [AW:0] rp;
  logic        empty;
  logic        full;
  logic        push;
  logic        pop;

  assign empty = (wp == rp);
  assign full  = (wp[AW] != rp[AW])
               && (wp[AW-1:0] == rp[AW-1:0]);
  // A pop on the same edge frees the slot, so a full push still lands.
  assign push  = wr & (idx == 2'd0) & (~full | pop);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wp <= '0;
      rp <= '0;
      for (int i = 0; i < TX_DEPTH; i++) mem[i] <= 8'h00;
    end else begin
      if (push) begin
        mem[wp[AW-1:0]] <= wb.dat_m[7:0];
        wp <= wp + (AW+1)'(1);
      end
      if (pop) rp <= rp + (AW+1)'(1);
    end
  end

  st_t         tx_st;
  st_t         tx_st_n;
  logic [15:0] tx_tmr;
  logic [15:0] tx_tmr_n;
  logic [2:0]  tx_cnt;
  logic [2:0]  tx_cnt_n;
  logic [7:0]  tx_sh;
  logic [7:0]  tx_sh_n;
  logic        tx_exp;
  logic        tx_busy;

  assign tx_exp  = (tx_tmr == 16'd0);
  assign tx_busy = ~empty | (tx_st != IDLE);

  always_comb begin
    tx_st_n  = tx_st;
    tx_tmr_n = tx_tmr - 16'd1;
    tx_cnt_n = tx_cnt;
    tx_sh_n  = tx_sh;
    pop      = 1'b0;
    unique case (tx_st)
      IDLE: begin
        tx_tmr_n = tx_tmr;
        if (!empty) begin
          pop      = 1'b1;
          tx_sh_n  = mem[rp[AW-1:0]];
          tx_tmr_n = div;
          tx_st_n  = START;
        end
      end
      START: if (tx_exp) begin
        tx_tmr_n = div;
        tx_cnt_n = 3'd0;
        tx_st_n  = DATA;
      end
      DATA: if (tx_exp) begin
        tx_tmr_n = div;
        tx_sh_n  = tx_sh >> 1;
        tx_cnt_n = tx_cnt + 3'd1;
        if (tx_cnt == 3'd7) tx_st_n = STOP;
      end
      STOP: if (tx_exp) begin
        tx_tmr_n = div;
        if (!empty) begin
          pop     = 1'b1;
          tx_sh_n = mem[rp[AW-1:0]];
          tx_st_n = START;
        end else begin
          tx_st_n = IDLE;
        end
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tx_st  <= IDLE;
      tx_tmr <= '0;
      tx_cnt <= '0;
      tx_sh  <= '0;
      txd    <= 1'b1;
    end else begin
      tx_st  <= tx_st_n;
      tx_tmr <= tx_tmr_n;
      tx_cnt <= tx_cnt_n;
      tx_sh  <= tx_sh_n;
      txd    <= (tx_st == START) ? 1'b0
              : (tx_st == DATA)  ? tx_sh[0]
              : 1'b1;
    end
  end

  logic        rx_s1;
  logic        rx_s2;
  logic        rx_prev;
  st_t         rx_st;
  st_t         rx_st_n;
  logic [15:0] rx_tmr;
  logic [15:0] rx_tmr_n;
  logic [2:0]  rx_cnt;
  logic [2:0]  rx_cnt_n;
  logic [7:0]  rx_sh;
  logic [7:0]  rx_sh_n;
  logic        rx_exp;
  logic        rx_done;
  logic        rx_bad;

  assign rx_exp = (rx_tmr == 16'd0);

  always_comb begin
    rx_st_n  = rx_st;
    rx_tmr_n = rx_tmr - 16'd1;
    rx_cnt_n = rx_cnt;
    rx_sh_n  = rx_sh;
    rx_done  = 1'b0;
    rx_bad   = 1'b0;
    unique case (rx_st)
      IDLE: begin
        rx_tmr_n = rx_tmr;
        if (rx_prev & ~rx_s2) begin
          rx_tmr_n = {1'b0, div[15:1]};
          rx_st_n  = START;
        end
      end
      START: if (rx_exp) begin
        rx_tmr_n = div;
        rx_cnt_n = 3'd0;
        rx_st_n  = rx_s2 ? IDLE : DATA;
      end
      DATA: if (rx_exp) begin
        rx_tmr_n = div;
        rx_sh_n  = {rx_s2, rx_sh[7:1]};
        rx_cnt_n = rx_cnt + 3'd1;
        if (rx_cnt == 3'd7) rx_st_n = STOP;
      end
      STOP: if (rx_exp) begin
        rx_done = rx_s2;
        rx_bad  = ~rx_s2;
        rx_st_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rx_s1   <= 1'b1;
      rx_s2   <= 1'b1;
      rx_prev <= 1'b1;
      rx_st   <= IDLE;
      rx_tmr  <= '0;
      rx_cnt  <= '0;
      rx_sh   <= '0;
    end else begin
      rx_s1   <= rxd;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      rx_st   <= rx_st_n;
      rx_tmr  <= rx_tmr_n;
      rx_cnt  <= rx_cnt_n;
      rx_sh   <= rx_sh_n;
    end
  end

  // Completion beats a same-edge DATA read; set beats a same-edge clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      div      <= DIV_RESET;
      rx_data  <= 8'h00;
      rx_valid <= 1'b0;
      rx_ovr   <= 1'b0;
      rx_ferr  <= 1'b0;
    end else begin
      if (wr && idx == 2'd2) div <= wb.dat_m;
      if (rx_done) begin
        rx_data  <= rx_sh;
        rx_valid <= 1'b1;
      end else if (data_rd) begin
        rx_valid <= 1'b0;
      end
      if (rx_done & rx_valid & ~data_rd) rx_ovr <= 1'b1;
      else if (stat_wr & wb.dat_m[3]) rx_ovr <= 1'b0;
      if (rx_bad) rx_ferr <= 1'b1;
      else if (stat_wr & wb.dat_m[4]) rx_ferr <= 1'b0;
    end
  end

  assign irq = rx_valid;

  always_comb begin
    wb.dat_s = 16'h0000;
    if (sel) begin
      unique case (1'b1)
        idx == 2'd0: wb.dat_s = {8'h00, rx_data};
        idx == 2'd1: wb.dat_s = {11'b0, rx_ferr, rx_ovr,
                                 tx_busy, full, rx_valid};
        idx == 2'd2: wb.dat_s = div;
        idx == 2'd3: wb.dat_s = 16'h0000;
      endcase
    end
  end
endmodule
